// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word SRAM responder; req_* valid/ready in, rsp_* valid/ready out, one request in flight
module dmem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          acc, err;
  assign acc = req_valid_i & ready_q;
  assign off = req_addr_i - BASE_ADDR;
  assign err = (req_addr_i[1:0] != 2'b0) | (off >= LIMIT);
  assign idx = off[AW+1:2];
  assign req_ready_o = ready_q;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    err_d = err_q;
    if (acc) begin
      state_d = (LATENCY == 1) ? RESP : WAIT;
      cnt_d = CNT_INIT;
      rdata_d = (err | req_we_i) ? '0 : mem[idx];
      err_d = err;
    end else if (state_q == WAIT) begin
      state_d = (cnt_q == '0) ? RESP : WAIT;
      cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
    end else if (state_q == RESP && rsp_ready_i) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ready_q <= state_d == IDLE;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i && acc && req_we_i && !err)
      for (int b = 0; b < 4; b++)
        if (req_wstrb_i[b]) mem[idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed stimulus with a timestamp-based reference model checked every cycle
module tb_dmem_responder;
  localparam int DEPTH = 64;
  localparam int LAT = 2;
  localparam logic [31:0] BASE = 32'h0;
  logic clk = 0;
  logic reset = 1;
  logic req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_wstrb = 0;
  logic req_ready_o, rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  int ncmp = 0, nfail = 0;
  int cyc = 0;
  logic [31:0] model_mem [DEPTH];
  logic m_ready = 0, m_busy = 0, m_rst = 0;
  int m_due = 0;
  logic [31:0] m_rdata = 0;
  logic m_err = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    logic [31:0] off;
    int ix;
    cyc++;
    if (reset) begin
      m_busy = 0;
      m_ready = 0;
      m_rst = 1;
    end else begin
      m_rst = 0;
      if (!m_busy) begin
        if (m_ready && req_valid) begin
          off = req_addr - BASE;
          m_err = (req_addr[1:0] != 0) || (off >= DEPTH * 4);
          ix = int'(off >> 2);
          if (!m_err && req_we)
            for (int b = 0; b < 4; b++)
              if (req_wstrb[b]) model_mem[ix][8*b +: 8] = req_wdata[8*b +: 8];
          m_rdata = (m_err || req_we) ? 32'h0 : model_mem[ix];
          m_busy = 1;
          m_due = cyc + LAT;
          m_ready = 0;
        end else m_ready = 1;
      end else if (cyc - 1 >= m_due && rsp_ready) begin
        m_busy = 0;
        m_ready = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("req_ready", {31'b0, req_ready_o}, {31'b0, m_ready});
      chk("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, m_busy && cyc >= m_due});
      if ((m_busy && cyc >= m_due) || m_rst) begin
        chk("rsp_rdata", rsp_rdata_o, m_rst ? 32'h0 : m_rdata);
        chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, m_rst ? 1'b0 : m_err});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    do begin @(negedge clk); n++; end while (!req_ready_o && n < 50);
    chk("ready_timeout", {31'b0, n < 50}, 32'h1);
  endtask

  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input int hold, output logic [31:0] rd, output logic e, output int lat);
    int t0, n;
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_wstrb = ws; rsp_ready = 0;
    wait_ready();
    @(posedge clk); #1;
    t0 = cyc;
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'hF;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid_o && n < 50);
    chk("rsp_timeout", {31'b0, n < 50}, 32'h1);
    lat = cyc - t0;
    rd = rsp_rdata_o;
    e = rsp_err_o;
    repeat (hold) @(negedge clk);
    @(posedge clk); #1; rsp_ready = 1;
    @(posedge clk); #1; rsp_ready = 0;
  endtask

  initial begin
    logic [31:0] rd;
    logic e;
    int lat, t1, t2, n;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    do_req(1, 32'h8, 32'hDEADBEEF, 4'hF, 0, rd, e, lat);
    chk("t1_store_err", {31'b0, e}, 32'h0);
    do_req(0, 32'h8, 32'h0, 4'h0, 0, rd, e, lat);
    chk("t1_load_data", rd, 32'hDEADBEEF);
    chk("t1_load_err", {31'b0, e}, 32'h0);
    chk("t1_latency", lat, LAT);
    do_req(1, 32'h4, 32'h11223344, 4'hF, 0, rd, e, lat);
    do_req(1, 32'h4, 32'hAABBCCDD, 4'b0101, 0, rd, e, lat);
    do_req(0, 32'h4, 32'h0, 4'h0, 0, rd, e, lat);
    chk("t2_merge", rd, 32'h11BB33DD);
    do_req(0, 32'h6, 32'h0, 4'h0, 0, rd, e, lat);
    chk("t3_misal_err", {31'b0, e}, 32'h1);
    chk("t3_misal_data", rd, 32'h0);
    do_req(0, DEPTH * 4, 32'h0, 4'h0, 0, rd, e, lat);
    chk("t3_oor_err", {31'b0, e}, 32'h1);
    chk("t3_oor_data", rd, 32'h0);
    do_req(1, DEPTH * 4, 32'h55555555, 4'hF, 0, rd, e, lat);
    chk("t3_oor_store_err", {31'b0, e}, 32'h1);
    do_req(1, 32'h6, 32'h66666666, 4'hF, 0, rd, e, lat);
    chk("t3_misal_store_err", {31'b0, e}, 32'h1);
    do_req(1, 32'hFFFF_FFFC, 32'h77777777, 4'hF, 0, rd, e, lat);
    chk("t3_wrap_err", {31'b0, e}, 32'h1);
    do_req(1, 32'h8, 32'h12345678, 4'h0, 0, rd, e, lat);
    chk("t3_zero_strb_err", {31'b0, e}, 32'h0);
    do_req(0, 32'h4, 32'h0, 4'h0, 0, rd, e, lat);
    chk("t3_unchanged4", rd, 32'h11BB33DD);
    do_req(0, 32'h8, 32'h0, 4'h0, 5, rd, e, lat);
    chk("t4_hold_data", rd, 32'hDEADBEEF);
    chk("t4_hold_post", rsp_rdata_o, 32'hDEADBEEF);
    @(posedge clk); #1;
    req_valid = 1; req_we = 0; req_addr = 32'h8; rsp_ready = 0;
    wait_ready();
    @(posedge clk); #1;
    req_valid = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("t5_ready", {31'b0, req_ready_o}, 32'h0);
    chk("t5_valid", {31'b0, rsp_valid_o}, 32'h0);
    chk("t5_rdata", rsp_rdata_o, 32'h0);
    chk("t5_err", {31'b0, rsp_err_o}, 32'h0);
    repeat (6) begin
      @(negedge clk);
      chk("t5_no_rsp", {31'b0, rsp_valid_o}, 32'h0);
    end
    do_req(0, 32'h8, 32'h0, 4'h0, 0, rd, e, lat);
    chk("t5_after", rd, 32'hDEADBEEF);
    @(posedge clk); #1;
    req_valid = 1; req_we = 1; req_addr = 32'h0; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF; rsp_ready = 1;
    wait_ready();
    @(posedge clk); #1;
    t1 = cyc;
    req_addr = 32'h4; req_wdata = 32'h0BADC0DE;
    wait_ready();
    @(posedge clk); #1;
    t2 = cyc;
    req_valid = 0;
    chk("t6_interval", t2 - t1, LAT + 2);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid_o && n < 50);
    chk("t6_rsp_timeout", {31'b0, n < 50}, 32'h1);
    @(posedge clk); #1; rsp_ready = 0;
    do_req(0, 32'h0, 32'h0, 4'h0, 0, rd, e, lat);
    chk("t6_word0", rd, 32'hCAFEF00D);
    do_req(0, 32'h4, 32'h0, 4'h0, 0, rd, e, lat);
    chk("t6_word1", rd, 32'h0BADC0DE);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
